// File: rtl/svc_rv_mem_arb_pkg.sv
// svc_rv_mem_arb_pkg: shared types and constants for the svc_rv instruction/data memory arbiter
package svc_rv_mem_arb_pkg;
    typedef enum logic {OWNER_IMEM, OWNER_DMEM} owner_t;
    localparam int RD_LATENCY = 1;
endpackage

// File: rtl/svc_arb_rr2.sv
// svc_arb_rr2: two-way grant logic; round-robin when SVC_RV_MEM_ARB_RR_EN is defined, fixed dmem priority otherwise
module svc_arb_rr2
    import svc_rv_mem_arb_pkg::*;
(
`ifdef SVC_RV_MEM_ARB_RR_EN
    input  logic clk,
`endif
    input  logic rst_n,
    input  logic imem_req,
    input  logic dmem_req,
    output logic imem_grant,
    output logic dmem_grant
);
    logic dmem_wins;
`ifdef SVC_RV_MEM_ARB_RR_EN
    owner_t last_grant;
    assign dmem_wins = last_grant == OWNER_IMEM;
    // remember who was served last so the next conflict goes to the other side
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= OWNER_IMEM;
        else if (imem_grant || dmem_grant)
            last_grant <= dmem_grant ? OWNER_DMEM : OWNER_IMEM;
    end
`else
    assign dmem_wins = 1'b1;
`endif
    // a lone requester is served at once; on conflict dmem_wins picks the side; nothing is granted in reset
    always_comb begin
        dmem_grant = rst_n && dmem_req && !(imem_req && !dmem_wins);
        imem_grant = rst_n && imem_req && !(dmem_req && dmem_wins);
    end
endmodule

// File: rtl/svc_rv_mem_arb.sv
// svc_rv_mem_arb: shares one 1-cycle-latency memory between fetch and data ports (SVC_RV_MEM_ARB_RR_EN selects round-robin)
module svc_rv_mem_arb
    import svc_rv_mem_arb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_arvalid,
    input  logic [31:0]       imem_araddr,
    output logic              imem_arready,
    output logic              imem_rvalid,
    output logic [XLEN-1:0]   imem_rdata,
    input  logic              dmem_ren,
    input  logic [31:0]       dmem_raddr,
    input  logic              dmem_we,
    input  logic [31:0]       dmem_waddr,
    input  logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN/8-1:0] dmem_wstrb,
    output logic              dmem_ready,
    output logic              dmem_rvalid,
    output logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata
);
    logic        imem_grant;
    logic        dmem_grant;
    logic        rd_grant;
    logic        pending;
    owner_t      owner;
    logic [31:0] dmem_addr;
    logic        unused_addr_bits;

    svc_arb_rr2 u_arb (
`ifdef SVC_RV_MEM_ARB_RR_EN
        .clk        (clk),
`endif
        .rst_n      (rst_n),
        .imem_req   (imem_arvalid),
        .dmem_req   (dmem_ren || dmem_we),
        .imem_grant (imem_grant),
        .dmem_grant (dmem_grant)
    );

    assign dmem_addr = dmem_we ? dmem_waddr : dmem_raddr;
    assign rd_grant  = imem_grant || (dmem_grant && dmem_ren);

    // steer the granted requester onto the memory port; strobes only ever accompany a write
    always_comb begin
        mem_en    = imem_grant || dmem_grant;
        mem_we    = dmem_grant && dmem_we;
        mem_addr  = dmem_grant ? dmem_addr[AW+1:2] : imem_araddr[AW+1:2];
        mem_wdata = dmem_wdata;
        mem_wstrb = mem_we ? dmem_wstrb : '0;
    end

    // track the outstanding read so its data returns to the requester that issued it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 1'b0;
            owner   <= OWNER_IMEM;
        end else begin
            pending <= rd_grant;
            if (rd_grant)
                owner <= dmem_grant ? OWNER_DMEM : OWNER_IMEM;
        end
    end

    assign imem_arready = imem_grant;
    assign dmem_ready   = dmem_grant;
    assign imem_rvalid  = pending && owner == OWNER_IMEM;
    assign dmem_rvalid  = pending && owner == OWNER_DMEM;
    assign imem_rdata   = mem_rdata;
    assign dmem_rdata   = mem_rdata;

    assign unused_addr_bits = ^{imem_araddr[31:AW+2], imem_araddr[1:0], dmem_addr[31:AW+2], dmem_addr[1:0]};

    a_no_rw_same_cycle: assert property (@(posedge clk) disable iff (!rst_n) !(dmem_ren && dmem_we));
endmodule

// File: tb/tb_svc_rv_mem_arb.sv
// tb_svc_rv_mem_arb: randomized scoreboard bench for svc_rv_mem_arb with a behavioural memory and arbitration model
module tb_svc_rv_mem_arb;
    localparam int XLEN = 32;
    localparam int AW   = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_arvalid = 1'b0;
    logic [31:0]       imem_araddr = '0;
    logic              imem_arready;
    logic              imem_rvalid;
    logic [XLEN-1:0]   imem_rdata;
    logic              dmem_ren = 1'b0;
    logic [31:0]       dmem_raddr = '0;
    logic              dmem_we = 1'b0;
    logic [31:0]       dmem_waddr = '0;
    logic [XLEN-1:0]   dmem_wdata = '0;
    logic [XLEN/8-1:0] dmem_wstrb = '0;
    logic              dmem_ready;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    svc_rv_mem_arb #(.XLEN(XLEN), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_arvalid (imem_arvalid),
        .imem_araddr  (imem_araddr),
        .imem_arready (imem_arready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .dmem_ren     (dmem_ren),
        .dmem_raddr   (dmem_raddr),
        .dmem_we      (dmem_we),
        .dmem_waddr   (dmem_waddr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_ready   (dmem_ready),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic [31:0] ram     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    rsp_t        q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          last_d = 1'b0;
    bit          ei, ed;
    bit          i_act, d_act, dw, rst;
    logic [31:0] ia, da, wd;
    logic [3:0]  ws;

    always @(posedge clk) cyc <= cyc + 1;

    // memory macro: byte-masked writes, registered reads
    always @(posedge clk) begin
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // drive one cycle of requests, check the combinational response, and record expected read data
    task automatic step(input bit r, input bit iv, input logic [31:0] iaddr, input bit dv, input bit dwr,
                        input logic [31:0] daddr, input logic [31:0] wdat, input logic [3:0] wstb);
        bit            pick_d;
        logic [AW-1:0] w;
        @(negedge clk);
        rst_n        = r;
        imem_arvalid = iv;
        imem_araddr  = iaddr;
        dmem_ren     = dv && !dwr;
        dmem_we      = dv && dwr;
        dmem_raddr   = dwr ? $urandom : daddr;
        dmem_waddr   = dwr ? daddr : $urandom;
        dmem_wdata   = wdat;
        dmem_wstrb   = wstb;
        #1;
`ifdef SVC_RV_MEM_ARB_RR_EN
        pick_d = !last_d;
`else
        pick_d = 1'b1;
`endif
        ei = r && iv && !(dv && pick_d);
        ed = r && dv && !(iv && !pick_d);
        w  = ed ? daddr[AW+1:2] : iaddr[AW+1:2];
        check("imem_arready", 32'(imem_arready), 32'(ei));
        check("dmem_ready", 32'(dmem_ready), 32'(ed));
        check("mem_en", 32'(mem_en), 32'(ei || ed));
        check("mem_we", 32'(mem_we), 32'(ed && dwr));
        check("mem_wstrb", 32'(mem_wstrb), (ed && dwr) ? 32'(wstb) : 32'd0);
        if (ei || ed) check("mem_addr", 32'(mem_addr), 32'(w));
        if (ed && dwr) check("mem_wdata", mem_wdata, wdat);
        if (!r) last_d = 1'b0;
        else if (ei || ed) last_d = ed;
        if (ei) q.push_back(rsp_t'{1'b0, ref_mem[w], cyc + 1});
        if (ed && !dwr) q.push_back(rsp_t'{1'b1, ref_mem[w], cyc + 1});
        if (ed && dwr)
            for (int b = 0; b < 4; b++)
                if (wstb[b]) ref_mem[w][8*b +: 8] = wdat[8*b +: 8];
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    // response monitor: every rvalid must match the oldest expected read, exactly on its due cycle
    always @(negedge clk) begin
        rsp_t m;
        if (imem_rvalid === 1'b1 || dmem_rvalid === 1'b1) begin
            check("rvalid_exclusive", 32'(imem_rvalid && dmem_rvalid), 32'd0);
            if (q.size() == 0) begin
                check("rvalid_unexpected", 32'({imem_rvalid, dmem_rvalid}), 32'd0);
            end else begin
                m = q.pop_front();
                check("rsp_port", 32'(dmem_rvalid), 32'(m.port));
                check("rsp_data", dmem_rvalid ? dmem_rdata : imem_rdata, m.data);
                check("rsp_cycle", 32'(cyc), 32'(m.due));
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            m = q.pop_front();
            check("rvalid_missing", 32'({imem_rvalid, dmem_rvalid}), m.port ? 32'd1 : 32'd2);
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[16]     = 32'h0000_0013;
        ref_mem[16] = 32'h0000_0013;
        repeat (2) step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'd0, 4'd0);
        step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("fetch_mem_addr", 32'(mem_addr), 32'h10);
        idle();
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'h3);
        idle();
        repeat (4) step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h204, 32'd0, 4'd0);
        idle();
        step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
        idle();
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
        step(1'b0, 1'b1, 32'h24, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
        idle();
        check("post_reset_dmem_rvalid", 32'(dmem_rvalid), 32'd0);
        i_act = 1'b0;
        d_act = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!i_act && $urandom_range(0, 2) != 0) begin
                i_act = 1'b1;
                ia    = $urandom;
            end
            if (!d_act && $urandom_range(0, 2) != 0) begin
                d_act = 1'b1;
                dw    = 1'($urandom_range(0, 1));
                da    = $urandom;
                wd    = $urandom;
                ws    = 4'($urandom);
            end
            rst = $urandom_range(0, 99) != 0;
            step(rst, i_act, ia, d_act, dw, da, wd, ws);
            if (ei) i_act = 1'b0;
            if (ed) d_act = 1'b0;
        end
        repeat (3) idle();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
